ahb_mtx_decode_param: RTL and testbench
=======================================

# ahb_mtx_decode_param

Parametrised AHB bus-matrix input-side decoder for the level-1 matrix. It decodes the input-stage address into one of NUM_PORTS output-stage selects, with priority and sticky-IDLE rules. It muxes the data-phase response back from the selected output stage and contains an integrated default slave. It adds a per-transfer wait-state watchdog that fails a hung slave with an AHB ERROR response and fences that port until it recovers.

## Interface
- NUM_PORTS, 4, output stages served (1..8)
- REGION_BASE, {NUM_PORTS{22'h3fffff}}, flat vector of 22-bit lower bounds on addr[31:10]; port i at bits [22i+21:22i]
- REGION_LIMIT, {NUM_PORTS{22'h000000}}, flat vector of 22-bit inclusive upper bounds; base>limit disables the region
- TIMEOUT_CYC, 256, wait-state limit before forced ERROR (0 disables, max 65535)
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset; asynchronous, active-low
- HREADYS  in  1  input-stage HREADY (transfer done)
- sel_dec  in  1  input-stage HSEL
- decode_addr_dec  in  22  HADDR[31:10]
- trans_dec  in  2  HTRANS
- active_dec_v  in  NUM_PORTS  output-stage active flags
- readyout_dec_v  in  NUM_PORTS  output-stage HREADYOUT
- resp_dec_v  in  2*NUM_PORTS  output-stage HRESP
- rdata_dec_v  in  32*NUM_PORTS  output-stage HRDATA
- ruser_dec_v  in  32*NUM_PORTS  output-stage HRUSER
- sel_dec_v  out  NUM_PORTS  one-hot output-stage HSEL
- active_dec  out  1  active flag of the addressed port
- HREADYOUTS  out  1  HREADY feedback to the input stage
- HRESPS  out  2  response (00 OKAY, 01 ERROR)
- HRDATAS  out  32  read data
- HRUSERS  out  32  user read data
- hung_mask  out  NUM_PORTS  ports fenced after a timeout
- timeout_pls  out  1  one-cycle pulse when a timeout fires

## Operation
- Address phase, combinational: addr_port = the lowest index i with base_i <= addr <= limit_i and hung_mask[i]=0.
- Sticky-IDLE override: if trans_dec==IDLE and data_port==p (p not default), addr_port=p.
- No match gives DEFAULT.
- sel_dec_v[addr_port] = sel_dec, all other bits 0. DEFAULT asserts no sel_dec_v bit.
- active_dec = active_dec_v[addr_port]; active_dec = 1 for DEFAULT.
- data_port register loads addr_port on every HREADYS=1 cycle. It also captures whether the transfer was NONSEQ/SEQ with sel_dec=1.
- Default slave for a captured IDLE/BUSY or unselected transfer: HREADYOUTS=1, HRESPS=OKAY.
- Default slave for a captured NONSEQ/SEQ: two-cycle ERROR.
  - Cycle 1: HREADYOUTS=0, HRESPS=01.
  - Cycle 2: HREADYOUTS=1, HRESPS=01.
- Data mux for a real port: HREADYOUTS, HRESPS, HRDATAS and HRUSERS come from port data_port.
- Data mux for DEFAULT: HRDATAS and HRUSERS are 0.
- Watchdog FSM states: RUN, TERR1, TERR2.
- RUN:
  - wait_cnt (16 bit) clears on every HREADYS=1 cycle.
  - wait_cnt increments while data_port is a real port and its readyout is 0.
  - When wait_cnt reaches TIMEOUT_CYC-1 with readyout still 0: go to TERR1, set hung_mask[data_port], pulse timeout_pls.
- TERR1: HREADYOUTS=0, HRESPS=01; go to TERR2.
- TERR2: HREADYOUTS=1, HRESPS=01; data_port then loads normally; go to RUN.
- In TERR1 and TERR2 the port's readyout, resp and data are ignored.
- hung_mask[i] clears on any cycle where readyout_dec_v[i]=1 and port i is not the current data_port.
- A fenced port decodes to DEFAULT. If the address also overlaps a lower-priority region, that region wins instead.

## Timing
- Reset values:
  - data_port=DEFAULT (captured IDLE), FSM=RUN, wait_cnt=0, hung_mask=0.
  - HREADYOUTS=1, HRESPS=00, HRDATAS=0, HRUSERS=0, timeout_pls=0.
  - sel_dec_v follows its combinational inputs.
- Address-phase outputs have zero latency. The data-phase mux switches the cycle after HREADYS=1.
- Timeout fires exactly TIMEOUT_CYC wait cycles into the data phase. The master sees ERROR completion at wait TIMEOUT_CYC+2.
- If the slave's readyout rises in the same cycle the count hits the limit, the slave completes normally and no timeout occurs.
- If hung_mask set and clear coincide, set wins.
- Reset asserted mid-transfer or in TERR1/TERR2 aborts immediately to the reset values.
- wait_cnt saturates and never wraps.
- TIMEOUT_CYC=0: the FSM stays in RUN and hung_mask stays 0.

## Test plan
- NUM_PORTS=2, port0 0x60090000-0x6009FFFF, port1 0x40030000-0x5002FFFF. NONSEQ to 0x60091000 -> sel_dec_v=01. Next cycle HRDATAS=rdata port0.
- NONSEQ to 0x10000000 (unmapped) -> sel_dec_v=00. Then HREADYOUTS 0/1 with HRESPS=01 on both cycles, HRDATAS=0.
- Transfer to port1, then IDLE at an unmapped address -> sel_dec_v=10 (sticky); active_dec=active_dec_v[1].
- TIMEOUT_CYC=4, port0 readyout held 0:
  - After 4 wait cycles timeout_pls=1 and hung_mask=01.
  - Then ERROR two-cycle completion.
  - Next NONSEQ to port0 goes to the default slave.
  - Raising readyout0 clears hung_mask.
- Overlapping regions, port0 and port1 both covering 0x40030000 -> port0 selected. With hung_mask[0]=1 -> port1 selected.
- Assert HRESETn low during TERR1 -> all outputs return to reset values, FSM=RUN.

Source files
------------

// File: rtl/ahb_mtx_decode_param.sv
// AHB matrix input-side decoder: region decode, response mux,
// integrated default slave and per-transfer wait-state watchdog.
module ahb_mtx_decode_param #(
  parameter int NUM_PORTS = 4,
  parameter logic [22*NUM_PORTS-1:0] REGION_BASE =
    {NUM_PORTS{22'h3fffff}},
  parameter logic [22*NUM_PORTS-1:0] REGION_LIMIT =
    {NUM_PORTS{22'h000000}},
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HREADYS,
  input  logic                    sel_dec,
  input  logic [21:0]             decode_addr_dec,
  input  logic [1:0]              trans_dec,
  input  logic [NUM_PORTS-1:0]    active_dec_v,
  input  logic [NUM_PORTS-1:0]    readyout_dec_v,
  input  logic [2*NUM_PORTS-1:0]  resp_dec_v,
  input  logic [32*NUM_PORTS-1:0] rdata_dec_v,
  input  logic [32*NUM_PORTS-1:0] ruser_dec_v,
  output logic [NUM_PORTS-1:0]    sel_dec_v,
  output logic                    active_dec,
  output logic                    HREADYOUTS,
  output logic [1:0]              HRESPS,
  output logic [31:0]             HRDATAS,
  output logic [31:0]             HRUSERS,
  output logic [NUM_PORTS-1:0]    hung_mask,
  output logic                    timeout_pls
);

  localparam int PW = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0] DEF = PW'(NUM_PORTS);
  localparam int TL = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [15:0] TLIM = 16'(TL);
  localparam bit WD_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    RUN,
    TERR1,
    TERR2
  } wd_e;

  wd_e state, state_nx;

  logic [PW-1:0] addr_port;
  logic [PW-1:0] data_port;
  logic          data_req;
  logic          def_st;
  logic [15:0]   wait_cnt;
  logic [NUM_PORTS-1:0] hung_nx;

  logic        data_real;
  logic        p_rdy;
  logic [1:0]  p_resp;
  logic [31:0] p_rdata;
  logic [31:0] p_ruser;
  logic        fire;

  // Lowest matching unfenced region wins; IDLE sticks to the data port.
  always_comb begin
    addr_port = DEF;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (!hung_mask[i] &&
          decode_addr_dec >= REGION_BASE[22*i +: 22] &&
          decode_addr_dec <= REGION_LIMIT[22*i +: 22])
        addr_port = PW'(i);
    end
    if (trans_dec == 2'b00 && data_port != DEF)
      addr_port = data_port;
  end

  always_comb begin
    sel_dec_v  = '0;
    active_dec = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_port == PW'(i)) begin
        sel_dec_v[i] = sel_dec;
        active_dec   = active_dec_v[i];
      end
    end
  end

  always_comb begin
    p_rdy   = 1'b1;
    p_resp  = 2'b00;
    p_rdata = '0;
    p_ruser = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port == PW'(i)) begin
        p_rdy   = readyout_dec_v[i];
        p_resp  = resp_dec_v[2*i +: 2];
        p_rdata = rdata_dec_v[32*i +: 32];
        p_ruser = ruser_dec_v[32*i +: 32];
      end
    end
  end

  assign data_real = (data_port != DEF);
  assign fire = WD_EN && (state == RUN) && data_real &&
                !p_rdy && (wait_cnt == TLIM);

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (fire) state_nx = TERR1;
      TERR1:   state_nx = TERR2;
      TERR2:   state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 2'b00;
    HRDATAS    = '0;
    HRUSERS    = '0;
    unique case (state)
      TERR1: begin
        HREADYOUTS = 1'b0;
        HRESPS     = 2'b01;
      end
      TERR2: begin
        HRESPS = 2'b01;
      end
      default: begin
        if (data_real) begin
          HREADYOUTS = p_rdy;
          HRESPS     = p_resp;
          HRDATAS    = p_rdata;
          HRUSERS    = p_ruser;
        end else if (data_req) begin
          HREADYOUTS = def_st;
          HRESPS     = 2'b01;
        end
      end
    endcase
  end

  // A set on the hung data port takes priority over a clear.
  always_comb begin
    hung_nx = hung_mask;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (fire && data_port == PW'(i))
        hung_nx[i] = 1'b1;
      else if (readyout_dec_v[i] && data_port != PW'(i))
        hung_nx[i] = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= RUN;
      data_port   <= DEF;
      data_req    <= 1'b0;
      def_st      <= 1'b0;
      wait_cnt    <= '0;
      hung_mask   <= '0;
      timeout_pls <= 1'b0;
    end else begin
      state       <= state_nx;
      timeout_pls <= fire;
      hung_mask   <= hung_nx;
      if (HREADYS) begin
        data_port <= addr_port;
        data_req  <= sel_dec & trans_dec[1];
        def_st    <= 1'b0;
      end else if (!data_real && data_req) begin
        def_st <= 1'b1;
      end
      if (HREADYS || state != RUN)
        wait_cnt <= '0;
      else if (data_real && !p_rdy && wait_cnt != 16'hffff)
        wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ahb_mtx_decode_param.sv
// Bench for ahb_mtx_decode_param: two ports, disjoint and overlapping
// region maps, default slave, watchdog timeout and recovery.
module tb_ahb_mtx_decode_param;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NS   = 2'b10;

  localparam logic [43:0] BASE_A  = {22'h1000C0, 22'h180240};
  localparam logic [43:0] LIMIT_A = {22'h1400BF, 22'h18027F};
  localparam logic [43:0] BASE_B  = {22'h1000C0, 22'h100000};
  localparam logic [43:0] LIMIT_B = {22'h1400BF, 22'h1BFFFF};

  localparam logic [21:0] A_P0 = 22'h180244;
  localparam logic [21:0] A_P1 = 22'h1000C0;
  localparam logic [21:0] A_UN = 22'h040000;

  localparam logic [31:0] RD0 = 32'hA0A0_0000;
  localparam logic [31:0] RD1 = 32'hB1B1_1111;
  localparam logic [31:0] RU0 = 32'hC0C0_0000;
  localparam logic [31:0] RU1 = 32'hD1D1_1111;

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] ruser;
  } rsp_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic hrdy, sel;
  logic [21:0] addr;
  logic [1:0] trans;
  logic [1:0] act_v, rdy_v;
  logic [3:0] resp_v;
  logic [63:0] rdata_v, ruser_v;

  logic [1:0] sel_v, hung;
  logic act, rdy_o, tp;
  logic [1:0] resp_o;
  logic [31:0] rdata_o, ruser_o;

  logic [1:0] o_sel, o_hung;
  logic o_act, o_rdy, o_tp;
  logic [1:0] o_resp;
  logic [31:0] o_rdata, o_ruser;

  rsp_t obs, o_obs, e;
  rsp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  assign obs   = {rdy_o, resp_o, rdata_o, ruser_o};
  assign o_obs = {o_rdy, o_resp, o_rdata, o_ruser};

  always #5 HCLK = ~HCLK;

  ahb_mtx_decode_param #(
    .NUM_PORTS(2), .REGION_BASE(BASE_A),
    .REGION_LIMIT(LIMIT_A), .TIMEOUT_CYC(4)
  ) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(hrdy),
    .sel_dec(sel), .decode_addr_dec(addr), .trans_dec(trans),
    .active_dec_v(act_v), .readyout_dec_v(rdy_v),
    .resp_dec_v(resp_v), .rdata_dec_v(rdata_v),
    .ruser_dec_v(ruser_v), .sel_dec_v(sel_v),
    .active_dec(act), .HREADYOUTS(rdy_o), .HRESPS(resp_o),
    .HRDATAS(rdata_o), .HRUSERS(ruser_o),
    .hung_mask(hung), .timeout_pls(tp)
  );

  ahb_mtx_decode_param #(
    .NUM_PORTS(2), .REGION_BASE(BASE_B),
    .REGION_LIMIT(LIMIT_B), .TIMEOUT_CYC(4)
  ) u_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(hrdy),
    .sel_dec(sel), .decode_addr_dec(addr), .trans_dec(trans),
    .active_dec_v(act_v), .readyout_dec_v(rdy_v),
    .resp_dec_v(resp_v), .rdata_dec_v(rdata_v),
    .ruser_dec_v(ruser_v), .sel_dec_v(o_sel),
    .active_dec(o_act), .HREADYOUTS(o_rdy), .HRESPS(o_resp),
    .HRDATAS(o_rdata), .HRUSERS(o_ruser),
    .hung_mask(o_hung), .timeout_pls(o_tp)
  );

  task automatic tick(input logic s, input logic [21:0] a,
                      input logic [1:0] t, input logic hr);
    @(posedge HCLK);
    #1;
    sel = s; addr = a; trans = t; hrdy = hr;
    #1;
  endtask

  task automatic test_reset;
    tick(1'b1, A_P0, NS, 1'b1);
    checks++;
    if (obs !== rsp_t'({1'b1, 2'b00, 32'h0, 32'h0})) begin
      errors++; $display("FAIL rst_out got %h exp reset", obs);
    end
    checks++;
    if (hung !== 2'b00 || tp !== 1'b0) begin
      errors++; $display("FAIL rst_wd got %b/%b exp 00/0", hung, tp);
    end
    checks++;
    if (sel_v !== 2'b01) begin
      errors++; $display("FAIL rst_sel got %b exp 01", sel_v);
    end
    tick(1'b0, A_UN, NS, 1'b1);
    HRESETn = 1'b1;
  endtask

  task automatic test_port0_read;
    tick(1'b1, A_P0, NS, 1'b1);
    checks++;
    if (sel_v !== 2'b01 || act !== 1'b1) begin
      errors++; $display("FAIL p0_sel got %b/%b exp 01/1", sel_v, act);
    end
    exp_q.push_back({1'b1, 2'b00, RD0, RU0});
    tick(1'b0, A_UN, IDLE, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL p0_read got %h exp %h", obs, e);
    end
  endtask

  task automatic test_unmapped;
    tick(1'b1, A_UN, NS, 1'b1);
    checks++;
    if (sel_v !== 2'b00 || act !== 1'b1) begin
      errors++; $display("FAIL un_sel got %b/%b exp 00/1", sel_v, act);
    end
    exp_q.push_back({1'b0, 2'b01, 32'h0, 32'h0});
    exp_q.push_back({1'b1, 2'b01, 32'h0, 32'h0});
    tick(1'b0, A_UN, IDLE, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL def_err1 got %h exp %h", obs, e);
    end
    tick(1'b0, A_UN, IDLE, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL def_err2 got %h exp %h", obs, e);
    end
    exp_q.push_back({1'b1, 2'b00, 32'h0, 32'h0});
    tick(1'b0, A_UN, IDLE, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL def_idle got %h exp %h", obs, e);
    end
  endtask

  task automatic test_sticky;
    act_v = 2'b01;
    tick(1'b1, A_P1, NS, 1'b1);
    checks++;
    if (sel_v !== 2'b10 || act !== 1'b0) begin
      errors++; $display("FAIL p1_sel got %b/%b exp 10/0", sel_v, act);
    end
    exp_q.push_back({1'b1, 2'b00, RD1, RU1});
    tick(1'b1, A_UN, IDLE, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL p1_read got %h exp %h", obs, e);
    end
    checks++;
    if (sel_v !== 2'b10 || act !== 1'b0) begin
      errors++; $display("FAIL sticky_sel got %b/%b exp 10/0", sel_v, act);
    end
    act_v = 2'b10;
    #1;
    checks++;
    if (act !== 1'b1) begin
      errors++; $display("FAIL sticky_act got %b exp 1", act);
    end
    exp_q.push_back({1'b1, 2'b00, RD1, RU1});
    tick(1'b0, A_UN, NS, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL sticky_data got %h exp %h", obs, e);
    end
  endtask

  task automatic test_overlap;
    act_v = 2'b11;
    tick(1'b1, A_P1, NS, 1'b1);
    checks++;
    if (o_sel !== 2'b01 || o_act !== 1'b1) begin
      errors++; $display("FAIL ovl_prio got %b/%b exp 01/1", o_sel, o_act);
    end
    tick(1'b0, A_UN, NS, 1'b1);
    checks++;
    if (o_obs !== rsp_t'({1'b1, 2'b00, RD0, RU0})) begin
      errors++; $display("FAIL ovl_data got %h exp p0", o_obs);
    end
  endtask

  task automatic test_timeout;
    tick(1'b1, A_P0, NS, 1'b1);
    rdy_v = 2'b10;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({1'b0, 2'b00, RD0, RU0});
    exp_q.push_back({1'b0, 2'b01, 32'h0, 32'h0});
    exp_q.push_back({1'b1, 2'b01, 32'h0, 32'h0});
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, A_UN, IDLE, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e || tp !== 1'b0) begin
        errors++; $display("FAIL wait%0d got %h/%b exp %h/0", k, obs, tp, e);
      end
    end
    tick(1'b0, A_UN, IDLE, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL terr1 got %h exp %h", obs, e);
    end
    checks++;
    if (tp !== 1'b1 || hung !== 2'b01 || o_tp !== 1'b1) begin
      errors++; $display("FAIL to_pulse got %b/%b/%b exp 1/01/1", tp, hung, o_tp);
    end
    tick(1'b1, A_P0, NS, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e || tp !== 1'b0) begin
      errors++; $display("FAIL terr2 got %h/%b exp %h/0", obs, tp, e);
    end
    checks++;
    if (sel_v !== 2'b00) begin
      errors++; $display("FAIL fenced got %b exp 00", sel_v);
    end
    exp_q.push_back({1'b0, 2'b01, 32'h0, 32'h0});
    exp_q.push_back({1'b1, 2'b01, 32'h0, 32'h0});
    tick(1'b0, A_UN, IDLE, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL fence_err1 got %h exp %h", obs, e);
    end
    tick(1'b0, A_UN, IDLE, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL fence_err2 got %h exp %h", obs, e);
    end
  endtask

  task automatic test_overlap_hung;
    tick(1'b1, A_P1, NS, 1'b1);
    checks++;
    if (o_sel !== 2'b10 || o_hung !== 2'b01) begin
      errors++; $display("FAIL ovl_fence got %b/%b exp 10/01", o_sel, o_hung);
    end
  endtask

  task automatic test_recover;
    tick(1'b0, A_UN, NS, 1'b1);
    rdy_v = 2'b11;
    tick(1'b0, A_UN, NS, 1'b1);
    checks++;
    if (hung !== 2'b00 || o_hung !== 2'b00) begin
      errors++; $display("FAIL recover got %b/%b exp 00/00", hung, o_hung);
    end
    tick(1'b1, A_P0, NS, 1'b1);
    checks++;
    if (sel_v !== 2'b01) begin
      errors++; $display("FAIL refresh_sel got %b exp 01", sel_v);
    end
    exp_q.push_back({1'b1, 2'b00, RD0, RU0});
    tick(1'b0, A_UN, NS, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL refresh_data got %h exp %h", obs, e);
    end
  endtask

  task automatic test_late_ready;
    tick(1'b1, A_P0, NS, 1'b1);
    rdy_v = 2'b10;
    for (int k = 0; k < 3; k++)
      exp_q.push_back({1'b0, 2'b00, RD0, RU0});
    exp_q.push_back({1'b1, 2'b00, RD0, RU0});
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, A_UN, IDLE, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin
        errors++; $display("FAIL late_wait%0d got %h exp %h", k, obs, e);
      end
    end
    tick(1'b0, A_UN, NS, 1'b1);
    rdy_v = 2'b11;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin
      errors++; $display("FAIL late_done got %h exp %h", obs, e);
    end
    tick(1'b0, A_UN, NS, 1'b1);
    checks++;
    if (tp !== 1'b0 || hung !== 2'b00) begin
      errors++; $display("FAIL late_nofire got %b/%b exp 0/00", tp, hung);
    end
  endtask

  task automatic test_reset_terr1;
    tick(1'b1, A_P0, NS, 1'b1);
    rdy_v = 2'b10;
    for (int k = 0; k < 5; k++)
      tick(1'b0, A_UN, IDLE, 1'b0);
    checks++;
    if (tp !== 1'b1 || obs !== rsp_t'({1'b0, 2'b01, 32'h0, 32'h0})) begin
      errors++; $display("FAIL terr1_again got %b/%h exp 1/terr1", tp, obs);
    end
    HRESETn = 1'b0;
    #1;
    checks++;
    if (obs !== rsp_t'({1'b1, 2'b00, 32'h0, 32'h0}) ||
        hung !== 2'b00 || tp !== 1'b0) begin
      errors++; $display("FAIL rst_terr1 got %h/%b/%b exp reset", obs, hung, tp);
    end
    tick(1'b0, A_UN, NS, 1'b1);
    HRESETn = 1'b1;
    tick(1'b0, A_UN, NS, 1'b1);
    checks++;
    if (obs !== rsp_t'({1'b1, 2'b00, 32'h0, 32'h0})) begin
      errors++; $display("FAIL rst_run got %h exp okay", obs);
    end
    rdy_v = 2'b11;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    hrdy = 1'b1; sel = 1'b0; addr = A_UN; trans = IDLE;
    act_v = 2'b01; rdy_v = 2'b11; resp_v = 4'b0000;
    rdata_v = {RD1, RD0}; ruser_v = {RU1, RU0};
    test_reset();
    test_port0_read();
    test_unmapped();
    test_sticky();
    test_overlap();
    test_timeout();
    test_overlap_hung();
    test_recover();
    test_late_ready();
    test_reset_terr1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
